// File: rtl/s_axis_rq_adapt_gen.sv
// Legacy TLP-stream to RQ descriptor-stream adapter: rebuilds the header as an
// RQ descriptor, realigns 3DW write payload by one dword and drives a registered output.
module s_axis_rq_adapt_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH/32
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic                  s_axis_rq_tvalid,
  output logic                  s_axis_rq_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_rq_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rq_tkeep,
  input  logic                  s_axis_rq_tlast,
  input  logic [3:0]            s_axis_rq_tuser,
  output logic                  s_axis_rq_tvalid_a,
  input  logic [3:0]            s_axis_rq_tready_a,
  output logic [DATA_WIDTH-1:0] s_axis_rq_tdata_a,
  output logic [KEEP_WIDTH-1:0] s_axis_rq_tkeep_a,
  output logic                  s_axis_rq_tlast_a,
  output logic [59:0]           s_axis_rq_tuser_a
);

  if (!((DATA_WIDTH == 128 || DATA_WIDTH == 256) && KEEP_WIDTH == DATA_WIDTH/32)) begin : g_bad_width
    $error("s_axis_rq_adapt_gen: DATA_WIDTH must be 128 or 256 with KEEP_WIDTH = DATA_WIDTH/32");
  end

  localparam logic [1:0] ST_HDR   = 2'd0;
  localparam logic [1:0] ST_BODY  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [59:0]           user;
  } beat_t;

  beat_t       beat_q, beat_d, flush_beat;
  logic        vld_q;
  logic [1:0]  state;
  logic [31:0] carry;
  logic [7:0]  be_q;
  logic        shift_q, disc_q;

  logic [31:0] dw0, dw1, dw2, dw3, dw2_d, dw3_d;
  logic        in_hdr, is_wr, hdr_shift, shift, last, extra, load;
  logic [63:0] addr;
  logic [3:0]  reqtype;

  assign dw0 = s_axis_rq_tdata[31:0];
  assign dw1 = s_axis_rq_tdata[63:32];
  assign dw2 = s_axis_rq_tdata[95:64];
  assign dw3 = s_axis_rq_tdata[127:96];

  assign in_hdr    = (state == ST_HDR);
  assign is_wr     = dw0[30];
  assign hdr_shift = is_wr & ~dw0[29];
  assign shift     = in_hdr ? hdr_shift : shift_q;
  // reads are single-beat by construction, whatever tlast says
  assign last      = s_axis_rq_tlast | (in_hdr & ~is_wr);
  assign extra     = shift & s_axis_rq_tlast & (&s_axis_rq_tkeep);
  assign load      = s_axis_rq_tready_a[0] | ~vld_q;

  assign s_axis_rq_tready = ~user_reset & (state != ST_FLUSH) & load;

  always_comb begin
    reqtype = 4'b1111;
    case ({dw0[30], dw0[28:24]})
      6'b0_00000: reqtype = 4'b0000;
      6'b0_00001: reqtype = 4'b0111;
      6'b1_00000: reqtype = 4'b0001;
      6'b0_00010: reqtype = 4'b0010;
      6'b1_00010: reqtype = 4'b0011;
      6'b0_00100: reqtype = 4'b1000;
      6'b1_00100: reqtype = 4'b1010;
      6'b0_00101: reqtype = 4'b1001;
      6'b1_00101: reqtype = 4'b1011;
      default:    reqtype = 4'b1111;
    endcase
  end

  assign addr  = dw0[29] ? {dw2, dw3[31:2], 2'b00} : {32'h0, dw2[31:2], 2'b00};
  assign dw2_d = {dw1[31:16], dw0[14] | s_axis_rq_tuser[1], reqtype, 1'b0, dw0[9:0]};
  assign dw3_d = {dw0[15] | s_axis_rq_tuser[0], 1'b0, dw0[13:12], dw0[22:20], 1'b0, 16'h0, dw1[15:8]};

  always_comb begin
    beat_d.data = shift ? {s_axis_rq_tdata[DATA_WIDTH-33:0], carry} : s_axis_rq_tdata;
    beat_d.keep = shift ? {s_axis_rq_tkeep[KEEP_WIDTH-2:0], 1'b1} : s_axis_rq_tkeep;
    beat_d.last = last & ~extra;
    beat_d.user = {48'h0, s_axis_rq_tuser[3], 3'b000, in_hdr ? dw1[7:0] : be_q};
    if (in_hdr) begin
      beat_d.data[127:0] = {dw3_d, dw2_d, addr};
      if (!is_wr) beat_d.keep = KEEP_WIDTH'(4'hF);
    end
  end

  assign flush_beat.data = {{(DATA_WIDTH-32){1'b0}}, carry};
  assign flush_beat.keep = KEEP_WIDTH'(1);
  assign flush_beat.last = 1'b1;
  assign flush_beat.user = {48'h0, disc_q, 3'b000, be_q};

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      vld_q   <= 1'b0;
      beat_q  <= '0;
      state   <= ST_HDR;
      carry   <= '0;
      be_q    <= '0;
      shift_q <= 1'b0;
      disc_q  <= 1'b0;
    end else if (load) begin
      if (state == ST_FLUSH) begin
        vld_q  <= 1'b1;
        beat_q <= flush_beat;
        state  <= ST_HDR;
      end else if (s_axis_rq_tvalid) begin
        vld_q  <= 1'b1;
        beat_q <= beat_d;
        carry  <= s_axis_rq_tdata[DATA_WIDTH-1 -: 32];
        disc_q <= s_axis_rq_tuser[3];
        if (in_hdr) begin
          be_q    <= dw1[7:0];
          shift_q <= hdr_shift;
        end
        state <= last ? (extra ? ST_FLUSH : ST_HDR) : ST_BODY;
      end else begin
        vld_q <= 1'b0;
      end
    end
  end

  assign s_axis_rq_tvalid_a = vld_q;
  assign s_axis_rq_tdata_a  = beat_q.data;
  assign s_axis_rq_tkeep_a  = beat_q.keep;
  assign s_axis_rq_tlast_a  = beat_q.last;
  assign s_axis_rq_tuser_a  = beat_q.user;

  logic unused;
  assign unused = &{1'b0, s_axis_rq_tready_a[3:1], s_axis_rq_tuser[2], dw0[31], dw0[23],
                    dw0[19:16], dw0[11:10], dw3[1:0]};

endmodule
